// File: rtl/bit_register_pkg.sv
// bit_register_pkg: shared defaults for the bit_register storage cells.
package bit_register_pkg;
    localparam int DEFAULT_WIDTH = 1;
endpackage

// File: rtl/bit_register_if.sv
// bit_register_if: data/enable bundle between a writer and a bit_register.
interface bit_register_if
    import bit_register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             load;
    modport master (output in, output load, input out);
    modport slave (input in, input load, output out);
endinterface

// File: rtl/bit_cell.sv
// bit_cell: 1-bit flop with load enable and synchronous reset to RESET_VALUE.
module bit_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    output logic out,
    input  logic in,
    input  logic load,
    input  logic clk,
    input  logic reset
);
    logic out_d, out_q;
    always_comb out_d = reset ? RESET_VALUE : (load ? in : out_q);
    always_ff @(posedge clk) out_q <= out_d;
    assign out = out_q;
endmodule

// File: rtl/bit_register.sv
// bit_register: WIDTH independent bit_cells sharing load and reset.
module bit_register
    import bit_register_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             clk,
    input  logic             reset
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bit_cell #(.RESET_VALUE(RESET_VALUE[i])) u_cell (
            .out  (out[i]),
            .in   (in[i]),
            .load (load),
            .clk  (clk),
            .reset(reset)
        );
    end
endmodule

// File: tb/tb_bit_register.sv
// tb_bit_register: 1-bit and 16-bit (reset A5A5) instances against a reference model.
module tb_bit_register;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic        exp_a;
    logic [15:0] exp_b;
    bit          valid = 1'b0;

    always #5 clk = ~clk;

    bit_register_if #(.WIDTH(1))  a_if ();
    bit_register_if #(.WIDTH(16)) b_if ();

    bit_register #(.WIDTH(1), .RESET_VALUE(1'b0)) u_a (
        .out(a_if.out), .in(a_if.in), .load(a_if.load), .clk(clk), .reset(reset)
    );
    bit_register #(.WIDTH(16), .RESET_VALUE(16'hA5A5)) u_b (
        .out(b_if.out), .in(b_if.in), .load(b_if.load), .clk(clk), .reset(reset)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check({tag, "_a"}, {15'b0, a_if.out}, {15'b0, exp_a});
        check({tag, "_b"}, b_if.out, exp_b);
    endtask

    // Inputs change 1 time unit after an edge; the pre-edge check proves there is no bypass.
    task automatic step(input string tag, input logic r, input logic la, input logic ia,
                        input logic lb, input logic [15:0] ib);
        reset     = r;
        a_if.load = la;
        a_if.in   = ia;
        b_if.load = lb;
        b_if.in   = ib;
        #1;
        if (valid) check_both({tag, "_pre"});
        @(posedge clk);
        if (r) begin
            exp_a = 1'b0;
            exp_b = 16'hA5A5;
        end else begin
            if (la) exp_a = ia;
            if (lb) exp_b = ib;
        end
        valid = 1'b1;
        #1;
        check_both(tag);
    endtask

    initial begin
        step("rst_load", 1, 1, 1, 1, 16'hFFFF);
        step("rst_rel", 0, 0, 1, 0, 16'hFFFF);
        step("ld_zero", 0, 1, 0, 1, 16'h0000);
        step("hold_zero", 0, 0, 0, 0, 16'h0000);
        step("hold_in1_a", 0, 0, 1, 0, 16'hFFFF);
        step("hold_in1_b", 0, 0, 1, 0, 16'hFFFF);
        step("rst_b", 1, 0, 0, 0, 16'h0000);
        step("ld_one", 0, 1, 1, 1, 16'h1234);
        step("hold_one", 0, 0, 0, 0, 16'hFFFF);
        step("hold_ffff1", 0, 0, 0, 0, 16'hFFFF);
        step("hold_ffff2", 0, 0, 0, 0, 16'hFFFF);
        step("rst_prio", 1, 1, 1, 1, 16'h5A5A);
        step("ld_again", 0, 1, 1, 1, 16'hBEEF);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check_both("mid_rst_hold");
        @(posedge clk);
        exp_a = 1'b0;
        exp_b = 16'hA5A5;
        #1;
        check_both("mid_rst_edge");
        for (int n = 0; n < 300; n++)
            step("rand", ($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 16'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
